seq_control: RTL and testbench
==============================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clock  in  1  sole clock, rising edge; clear  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have these inputs: ir  in  32  instruction register contents; con  in  1  branch-condition flag from CON FF.
REQ-003 The block SHALL have these bus-driver strobes: PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout  out  1 each.
REQ-004 The block SHALL have these load and memory strobes: PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, CONin, Read, Write  out  1 each.
REQ-005 The block SHALL have these register-select and ALU outputs: Gra, Grb, Grc  out  1 each, selecting ir[26:23], ir[22:19], ir[18:15]; op  out  5  ALU opcode.
REQ-006 The block SHALL have these remaining outputs: C_sext  out  32  ir[18:0] sign-extended; run  out  1  high unless halted; step  out  4  current T-step, for debug.

Function
REQ-007 The block SHALL be a Moore FSM with states RST, T0..T7, HALT; all strobes SHALL be combinational in the state and the registered ir, and SHALL default to 0.
REQ-008 C_sext SHALL always equal {13{ir[18]}, ir[18:0]}.
REQ-009 op SHALL be 5'b00000 in any step that does not assert Zlowin.
REQ-010 ALU codes SHALL be: ADD=00011, SUB=00100, AND=00101, OR=00110, INC (bus+1)=11100.
REQ-011 Fetch SHALL run as follows for every instruction:
  - T0: PCout, MARin, op=INC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
REQ-012 Decode SHALL occur at the end of T2 on opcode ir[31:27]; each class SHALL return to T0 after its last step.
REQ-013 R-type (opcode 00011..00110) SHALL execute as:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op=ir[31:27], Zlowin.
  - T5: Zlowout, Gra, Rin.
REQ-014 addi (01100) SHALL execute as:
  - T3: Grb, BAout, Yin.
  - T4: Cout, op=ADD, Zlowin.
  - T5: Zlowout, Gra, Rin.
REQ-015 ld (00000) SHALL execute as:
  - T3: Grb, BAout, Yin.
  - T4: Cout, op=ADD, Zlowin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
REQ-016 st (00001) SHALL run T3..T5 as ld, then T6: Gra, Rout, Write; it SHALL have no T7.
REQ-017 br (10010) SHALL execute as:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, op=ADD, Zlowin.
  - T6: Zlowout and PCin only if con=1 at T6; otherwise no strobes.
REQ-018 nop (11010) and any undefined opcode SHALL return from T2 directly to T0, with PC already incremented.
REQ-019 halt (11011) SHALL enter HALT after T2; HALT SHALL assert no strobes, drive run=0, and be exited only by clear.
REQ-020 Read and Write SHALL never be asserted in the same cycle, and Rin and Rout SHALL never be asserted in the same cycle.
REQ-021 At most one bus-driver strobe SHALL be high in any cycle.
REQ-022 step SHALL encode T0..T7 as 0..7, RST as 4'hE, and HALT as 4'hF.
REQ-023 Instruction latency SHALL be: R-type and addi 6 cycles, ld 8, st 7, br 7, nop 3.

Reset
REQ-024 Asserting clear SHALL immediately and asynchronously force state RST, with all strobes 0, op=0, run=1, step=4'hE.
REQ-025 The first rising clock edge with clear low SHALL move RST to T0.
REQ-026 clear asserted mid-instruction SHALL abandon that instruction with no further strobes.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Reset then release: step=E, then 0,1,2 on successive edges; PCout, MARin, Zlowin and op=11100 high in T0.
  - ir=add R1,R2,R3 (0x18918000): T4 op=00011 with Grc and Rout; T5 Gra and Rin; back in T0 at cycle 6.
  - ir=ld R2,0x55(R0): T3 BAout; T4 C_sext=0x00000055; T6 Read; T7 Rin; eight cycles total.
  - ir=st, C=-1 (ir[18:0]=0x7FFFF): C_sext=0xFFFFFFFF; T6 Write=1 with Read=0.
  - br with con=0, then again with con=1: PCin absent in T6 for con=0 and present for con=1.
  - halt: run drops after T2 and step=F is held 20 cycles; clear mid-T4 of an add forces step=E and no Rin.

Source files
------------

// File: rtl/seq_control_if.sv
// Control-word bundle between the sequencer and the datapath.
// The sequencer side drives every strobe and reads the instruction register and the branch flag.
interface seq_control_if;
    logic [31:0] ir;
    logic        con;

    logic        PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, CONin;
    logic        Read, Write;
    logic        Gra, Grb, Grc;
    logic [4:0]  op;
    logic [31:0] C_sext;
    logic        run;
    logic [3:0]  step;

    modport master (
        input  ir, con,
        output PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout,
        output PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, CONin,
        output Read, Write, Gra, Grb, Grc, op, C_sext, run, step
    );

    modport slave (
        output ir, con,
        input  PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout,
        input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin, CONin,
        input  Read, Write, Gra, Grb, Grc, op, C_sext, run, step
    );
endinterface

// File: rtl/seq_control.sv
// Moore control sequencer: fetch in T0..T2, decode at the end of T2, then execute the instruction class.
// All strobes come from the current T-step and the instruction register.
module seq_control (
    input  logic         clock,
    input  logic         clear,
    seq_control_if.master bus
);
    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_T7   = 4'h7,
        S_RST  = 4'hE,
        S_HALT = 4'hF
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_INC  = 5'b11100;
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00001;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    state_t     r_state;
    state_t     w_next_state;
    logic [4:0] w_opc;
    logic       w_is_rtype, w_is_ld, w_is_st, w_is_addi, w_is_br, w_is_halt;

    assign w_opc      = bus.ir[31:27];
    assign w_is_rtype = (w_opc >= 5'b00011) && (w_opc <= 5'b00110);
    assign w_is_ld    = (w_opc == OPC_LD);
    assign w_is_st    = (w_opc == OPC_ST);
    assign w_is_addi  = (w_opc == OPC_ADDI);
    assign w_is_br    = (w_opc == OPC_BR);
    assign w_is_halt  = (w_opc == OPC_HALT);

    assign bus.C_sext = {{13{bus.ir[18]}}, bus.ir[18:0]};
    assign bus.step   = r_state;
    assign bus.run    = (r_state != S_HALT);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= S_RST;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_RST:  w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_T2;
            S_T2: begin
                if (w_is_rtype || w_is_addi || w_is_ld || w_is_st || w_is_br) w_next_state = S_T3;
                else if (w_is_halt) w_next_state = S_HALT;
                else                w_next_state = S_T0;
            end
            S_T3:   w_next_state = S_T4;
            S_T4:   w_next_state = S_T5;
            S_T5:   w_next_state = (w_is_ld || w_is_st || w_is_br) ? S_T6 : S_T0;
            S_T6:   w_next_state = w_is_ld ? S_T7 : S_T0;
            S_T7:   w_next_state = S_T0;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_RST;
        endcase
    end

    always_comb begin
        bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
        bus.Rout  = 1'b0; bus.BAout  = 1'b0; bus.Cout    = 1'b0;
        bus.PCin  = 1'b0; bus.MARin  = 1'b0; bus.MDRin   = 1'b0; bus.IRin     = 1'b0;
        bus.Yin   = 1'b0; bus.Zlowin = 1'b0; bus.Zhighin = 1'b0; bus.Rin      = 1'b0;
        bus.CONin = 1'b0; bus.Read   = 1'b0; bus.Write   = 1'b0;
        bus.Gra   = 1'b0; bus.Grb    = 1'b0; bus.Grc     = 1'b0;
        bus.op    = 5'b00000;
        unique case (r_state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.Zlowin = 1'b1; bus.op = OP_INC;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                if (w_is_rtype) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (w_is_addi || w_is_ld || w_is_st) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else if (w_is_br) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_rtype) begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.op = w_opc;
                end else if (w_is_addi || w_is_ld || w_is_st) begin
                    bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op = OP_ADD;
                end else if (w_is_br) begin
                    bus.PCout = 1'b1; bus.Yin = 1'b1;
                end
            end
            S_T5: begin
                if (w_is_rtype || w_is_addi) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (w_is_ld || w_is_st) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                end else if (w_is_br) begin
                    bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op = OP_ADD;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    bus.Read = 1'b1; bus.MDRin = 1'b1;
                end else if (w_is_st) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Write = 1'b1;
                end else if (w_is_br && bus.con) begin
                    // The branch target already sits in Z; only commit it when the condition held.
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1;
                end
            end
            S_T7: begin
                if (w_is_ld) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control: each instruction's per-step control word is queued by the driver
// and compared by a monitor on every falling clock edge.
module tb_seq_control;
    localparam int W = 63;

    localparam logic [20:0] M_PCOUT   = 21'(1) << 20;
    localparam logic [20:0] M_MDROUT  = 21'(1) << 19;
    localparam logic [20:0] M_ZLOWOUT = 21'(1) << 18;
    localparam logic [20:0] M_ROUT    = 21'(1) << 16;
    localparam logic [20:0] M_BAOUT   = 21'(1) << 15;
    localparam logic [20:0] M_COUT    = 21'(1) << 14;
    localparam logic [20:0] M_PCIN    = 21'(1) << 13;
    localparam logic [20:0] M_MARIN   = 21'(1) << 12;
    localparam logic [20:0] M_MDRIN   = 21'(1) << 11;
    localparam logic [20:0] M_IRIN    = 21'(1) << 10;
    localparam logic [20:0] M_YIN     = 21'(1) << 9;
    localparam logic [20:0] M_ZLOWIN  = 21'(1) << 8;
    localparam logic [20:0] M_RIN     = 21'(1) << 6;
    localparam logic [20:0] M_CONIN   = 21'(1) << 5;
    localparam logic [20:0] M_READ    = 21'(1) << 4;
    localparam logic [20:0] M_WRITE   = 21'(1) << 3;
    localparam logic [20:0] M_GRA     = 21'(1) << 2;
    localparam logic [20:0] M_GRB     = 21'(1) << 1;
    localparam logic [20:0] M_GRC     = 21'(1) << 0;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_INC  = 5'b11100;

    logic clock;
    logic clear;
    seq_control_if bus();

    seq_control u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [31:0]  cur_c;
    int           checks;
    int           failures;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_nm;
    logic [6:0]   mon_drv;

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act = {bus.step, bus.run,
                       bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.Rout, bus.BAout, bus.Cout,
                       bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
                       bus.Rin, bus.CONin, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc,
                       bus.op, bus.C_sext};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h (step,run,strobes,op,C_sext)", mon_nm, mon_act, mon_exp);
            end
            mon_drv = {bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.Rout, bus.BAout, bus.Cout};
            checks++;
            if ((bus.Read && bus.Write) || (bus.Rin && bus.Rout) || ($countones(mon_drv) > 1)) begin
                failures++;
                $display("FAIL %s_exclusive actual=rd%b wr%b rin%b rout%b drv%b required=no overlap",
                         mon_nm, bus.Read, bus.Write, bus.Rin, bus.Rout, mon_drv);
            end
        end
    end

    // driver tasks
    task automatic push(input string nm, input logic [3:0] st, input logic [20:0] m, input logic [4:0] opv);
        exp_q.push_back({st, (st != 4'hF), m, opv, cur_c});
        name_q.push_back(nm);
    endtask

    task automatic push_fetch(input string nm);
        push({nm, "_t0"}, 4'h0, M_PCOUT | M_MARIN | M_ZLOWIN, OP_INC);
        push({nm, "_t1"}, 4'h1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, OP_NONE);
        push({nm, "_t2"}, 4'h2, M_MDROUT | M_IRIN, OP_NONE);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // new ir/con are applied just after the edge that enters T0, where the next state ignores ir
    task automatic launch(input logic [31:0] ir_v, input logic con_v);
        @(posedge clock);
        #1;
        bus.ir  = ir_v;
        bus.con = con_v;
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        bus.ir   = 32'h0;
        bus.con  = 1'b0;
        cur_c    = 32'h0;

        @(negedge clock);
        #1;
        push("reset", 4'hE, 21'h0, OP_NONE);
        drain();
        clear = 1'b0;

        cur_c = 32'h0;
        push_fetch("nop");
        launch(32'hD000_0000, 1'b0);

        cur_c = 32'h0001_8000;
        push_fetch("add");
        push("add_t3", 4'h3, M_GRB | M_ROUT | M_YIN, OP_NONE);
        push("add_t4", 4'h4, M_GRC | M_ROUT | M_ZLOWIN, OP_ADD);
        push("add_t5", 4'h5, M_ZLOWOUT | M_GRA | M_RIN, OP_NONE);
        launch(32'h1891_8000, 1'b0);

        cur_c = 32'h0001_8000;
        push_fetch("sub");
        push("sub_t3", 4'h3, M_GRB | M_ROUT | M_YIN, OP_NONE);
        push("sub_t4", 4'h4, M_GRC | M_ROUT | M_ZLOWIN, OP_SUB);
        push("sub_t5", 4'h5, M_ZLOWOUT | M_GRA | M_RIN, OP_NONE);
        launch(32'h2091_8000, 1'b0);

        cur_c = 32'h0000_0005;
        push_fetch("addi");
        push("addi_t3", 4'h3, M_GRB | M_BAOUT | M_YIN, OP_NONE);
        push("addi_t4", 4'h4, M_COUT | M_ZLOWIN, OP_ADD);
        push("addi_t5", 4'h5, M_ZLOWOUT | M_GRA | M_RIN, OP_NONE);
        launch(32'h6208_0005, 1'b0);

        cur_c = 32'h0000_0055;
        push_fetch("ld");
        push("ld_t3", 4'h3, M_GRB | M_BAOUT | M_YIN, OP_NONE);
        push("ld_t4", 4'h4, M_COUT | M_ZLOWIN, OP_ADD);
        push("ld_t5", 4'h5, M_ZLOWOUT | M_MARIN, OP_NONE);
        push("ld_t6", 4'h6, M_READ | M_MDRIN, OP_NONE);
        push("ld_t7", 4'h7, M_MDROUT | M_GRA | M_RIN, OP_NONE);
        launch(32'h0100_0055, 1'b0);

        cur_c = 32'hFFFF_FFFF;
        push_fetch("st");
        push("st_t3", 4'h3, M_GRB | M_BAOUT | M_YIN, OP_NONE);
        push("st_t4", 4'h4, M_COUT | M_ZLOWIN, OP_ADD);
        push("st_t5", 4'h5, M_ZLOWOUT | M_MARIN, OP_NONE);
        push("st_t6", 4'h6, M_GRA | M_ROUT | M_WRITE, OP_NONE);
        launch(32'h0987_FFFF, 1'b0);

        cur_c = 32'h0000_0010;
        push_fetch("br0");
        push("br0_t3", 4'h3, M_GRA | M_ROUT | M_CONIN, OP_NONE);
        push("br0_t4", 4'h4, M_PCOUT | M_YIN, OP_NONE);
        push("br0_t5", 4'h5, M_COUT | M_ZLOWIN, OP_ADD);
        push("br0_t6", 4'h6, 21'h0, OP_NONE);
        launch(32'h9080_0010, 1'b0);

        push_fetch("br1");
        push("br1_t3", 4'h3, M_GRA | M_ROUT | M_CONIN, OP_NONE);
        push("br1_t4", 4'h4, M_PCOUT | M_YIN, OP_NONE);
        push("br1_t5", 4'h5, M_COUT | M_ZLOWIN, OP_ADD);
        push("br1_t6", 4'h6, M_ZLOWOUT | M_PCIN, OP_NONE);
        launch(32'h9080_0010, 1'b1);

        cur_c = 32'h0;
        push_fetch("undef");
        launch(32'h7800_0000, 1'b0);

        // add abandoned by clear in the middle of T4
        cur_c = 32'h0001_8000;
        push_fetch("addclr");
        push("addclr_t3", 4'h3, M_GRB | M_ROUT | M_YIN, OP_NONE);
        push("addclr_t4", 4'h4, M_GRC | M_ROUT | M_ZLOWIN, OP_ADD);
        launch(32'h1891_8000, 1'b0);
        clear = 1'b1;
        for (int i = 0; i < 3; i++) push("addclr_rst", 4'hE, 21'h0, OP_NONE);
        drain();
        clear = 1'b0;

        cur_c = 32'h0;
        push_fetch("halt");
        for (int i = 0; i < 20; i++) push("halt_hold", 4'hF, 21'h0, OP_NONE);
        launch(32'hD800_0000, 1'b0);

        clear = 1'b1;
        push("halt_clear", 4'hE, 21'h0, OP_NONE);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
